// File: rtl/cgra_tile_config_decoder_if.sv
// Configuration stream bus seen by every tile: one address/data pair per clock.
// Ports: config_addr_in [31:24] reg, [23:16] feature, [15:0] tile (0 = NOP); config_data_in.
interface cgra_tile_config_decoder_if;
    logic [31:0] config_addr_in;
    logic [31:0] config_data_in;

    modport master (
        output config_addr_in,
        output config_data_in
    );

    modport slave (
        input config_addr_in,
        input config_data_in
    );
endinterface

// File: rtl/cgra_tile_config_decoder.sv
// Per-tile config decoder: captures matching writes into a register bank and flags done.
// Ports: clk_in, reset_in (sync, active-high), cfg bus (slave), config_out, config_done_out,
// config_err_out, write_count_out, read_data_out (only when CONFIG_READBACK_EN is defined).
module cgra_tile_config_decoder #(
    parameter logic [15:0] TILE_ID      = 16'h0000,
    parameter logic [7:0]  FEATURE_ID   = 8'h00,
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned IDLE_TIMEOUT = 4
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    cgra_tile_config_decoder_if.slave cfg,
    output logic [NUM_REGS*32-1:0]    config_out,
    output logic                      config_done_out,
    output logic                      config_err_out,
    output logic [15:0]               write_count_out
`ifdef CONFIG_READBACK_EN
    ,
    output logic [31:0]               read_data_out
`endif
);

    localparam int unsigned CW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] idle_cnt, idle_nxt;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [7:0]  reg_idx;
    logic        addr_hit;
    logic        in_range;
    logic        wr_en;
    logic        wr_oor;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= cfg.config_addr_in;
            data_q <= cfg.config_data_in;
        end
    end

    assign reg_idx  = addr_q[31:24];
    assign addr_hit = (addr_q != '0) &&
                      (addr_q[15:0] == TILE_ID) &&
                      (addr_q[23:16] == FEATURE_ID);
    assign in_range = ({24'b0, reg_idx} < NUM_REGS);
    assign wr_en    = addr_hit && in_range;
    assign wr_oor   = addr_hit && !in_range;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            config_out <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (reg_idx == 8'(i))
                    config_out[32*i +: 32] <= data_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            write_count_out <= '0;
            config_err_out  <= 1'b0;
        end else begin
            if (wr_en && write_count_out != 16'hFFFF)
                write_count_out <= write_count_out + 16'd1;
            if (wr_oor)
                config_err_out <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= EMPTY;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // An accepted write always wins over the timeout, reopening the load window.
    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        unique case (state)
            EMPTY: begin
                if (wr_en) begin
                    state_nxt = LOADING;
                    idle_nxt  = '0;
                end
            end
            LOADING: begin
                if (wr_en)
                    idle_nxt = '0;
                else if (idle_cnt == CW'(IDLE_TIMEOUT))
                    state_nxt = DONE;
                else
                    idle_nxt = idle_cnt + CW'(1);
            end
            DONE: begin
                if (wr_en) begin
                    state_nxt = LOADING;
                    idle_nxt  = '0;
                end
            end
            default: begin
                state_nxt = EMPTY;
                idle_nxt  = '0;
            end
        endcase
    end

    assign config_done_out = (state == DONE);

`ifdef CONFIG_READBACK_EN
    logic [31:0] old_word;

    always_comb begin
        old_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (reg_idx == 8'(i))
                old_word = config_out[32*i +: 32];
        end
    end

    // Returns the contents the write is about to replace.
    always_ff @(posedge clk_in) begin
        if (reset_in)
            read_data_out <= '0;
        else if (wr_en)
            read_data_out <= old_word;
        else if (wr_oor)
            read_data_out <= '0;
    end
`endif

endmodule

// File: tb/tb_cgra_tile_config_decoder.sv
// Randomized + directed bench for cgra_tile_config_decoder against a behavioural model.
// Honours CONFIG_READBACK_EN for the read_data_out port.
module tb_cgra_tile_config_decoder;

    localparam logic [15:0] TID = 16'h0005;
    localparam int          NR  = 8;
    localparam int          TO  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] config_out;
    logic         done;
    logic         err;
    logic [15:0]  count;
`ifdef CONFIG_READBACK_EN
    logic [31:0]  rd;
`endif

    int checks = 0;
    int passes = 0;
    bit checking = 0;

    cgra_tile_config_decoder_if bus ();

    cgra_tile_config_decoder #(
        .TILE_ID(TID),
        .FEATURE_ID(8'h00),
        .NUM_REGS(NR),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk_in(clk),
        .reset_in(rst),
        .cfg(bus.slave),
        .config_out(config_out),
        .config_done_out(done),
        .config_err_out(err),
        .write_count_out(count)
`ifdef CONFIG_READBACK_EN
        ,
        .read_data_out(rd)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: tracks the pair captured last edge and the edge of the last commit.
    logic [31:0] m_regs [256];
    logic [15:0] m_count;
    logic        m_err;
    logic [31:0] m_rd;
    logic [31:0] p_addr, p_data;
    int          e = 0;
    int          m_last_w;
    bit          m_wrote;

    initial begin
        for (int i = 0; i < 256; i++) m_regs[i] = '0;
    end

    always @(posedge clk) begin
        e <= e + 1;
        if (rst) begin
            for (int i = 0; i < 256; i++) m_regs[i] <= '0;
            m_count <= '0;
            m_err   <= 1'b0;
            m_rd    <= '0;
            m_wrote <= 1'b0;
            m_last_w <= 0;
            p_addr  <= '0;
            p_data  <= '0;
        end else begin
            if (p_addr != 0 && p_addr[15:0] == TID && p_addr[23:16] == 8'h00) begin
                if (int'(p_addr[31:24]) < NR) begin
                    m_rd <= m_regs[p_addr[31:24]];
                    m_regs[p_addr[31:24]] <= p_data;
                    if (m_count != 16'hFFFF) m_count <= m_count + 16'd1;
                    m_last_w <= e + 1;
                    m_wrote  <= 1'b1;
                end else begin
                    m_err <= 1'b1;
                    m_rd  <= '0;
                end
            end
            p_addr <= bus.config_addr_in;
            p_data <= bus.config_data_in;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    function automatic logic [255:0] exp_bank();
        logic [255:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = m_regs[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("bank", config_out, exp_bank());
            chk("count", {240'b0, count}, {240'b0, m_count});
            chk("err", {255'b0, err}, {255'b0, m_err});
            chk("done", {255'b0, done},
                {255'b0, (m_wrote && e >= m_last_w + TO + 1) ? 1'b1 : 1'b0});
`ifdef CONFIG_READBACK_EN
            chk("rd", {224'b0, rd}, {224'b0, m_rd});
`endif
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d);
        bus.config_addr_in = a;
        bus.config_data_in = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 32'h0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] wa(input int idx);
        return {8'(idx), 8'h00, TID};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        logic [31:0] a;
        rst = 1'b1;
        bus.config_addr_in = '0;
        bus.config_data_in = '0;
        @(negedge clk);
        @(negedge clk);
        checking = 1;
        rst = 1'b0;

        // Single write, then timeout to done.
        drive(32'h0200_0005, 32'hDEAD_BEEF);
        drive(32'h0, 32'h0);
        chk("lit_reg2", config_out[95:64], 32'hDEAD_BEEF);
        chk("lit_count1", count, 16'd1);
        chk("lit_others", config_out & ~{160'b0, 32'hFFFF_FFFF, 64'b0}, 256'b0);
        for (int k = 0; k < TO; k++) begin
            drive(32'h0, 32'h0);
            chk("lit_done_low", done, 1'b0);
        end
        drive(32'h0, 32'h0);
        chk("lit_done_rise", done, 1'b1);

        // Filtering.
        do_reset();
        drive(32'h0200_0006, 32'h1234_5678);
        drive(32'h0201_0005, 32'h1234_5678);
        drive(32'h0, 32'hFFFF_FFFF);
        repeat (6) drive(32'h0, 32'h0);
        chk("lit_filt_count", count, 16'd0);
        chk("lit_filt_bank", config_out, 256'b0);
        chk("lit_filt_done", done, 1'b0);

        // Out of range is sticky.
        drive(32'h0900_0005, 32'h1234);
        drive(32'h0, 32'h0);
        chk("lit_err_set", err, 1'b1);
        chk("lit_err_nocount", count, 16'd0);
        drive(wa(3), 32'h55);
        drive(32'h0, 32'h0);
        chk("lit_err_sticky", err, 1'b1);
        chk("lit_err_count", count, 16'd1);

        // Back-to-back, then reopen after done.
        do_reset();
        chk("lit_rst_err", err, 1'b0);
        for (int i = 0; i < NR; i++) drive(wa(i), 32'(i + 1));
        drive(32'h0, 32'h0);
        chk("lit_b2b_count", count, 16'd8);
        chk("lit_b2b_reg0", config_out[31:0], 32'd1);
        chk("lit_b2b_reg7", config_out[255:224], 32'd8);
        repeat (TO + 1) drive(32'h0, 32'h0);
        chk("lit_b2b_done", done, 1'b1);
        drive(wa(0), 32'hAA);
        chk("lit_reopen_hold", done, 1'b1);
        drive(32'h0, 32'h0);
        chk("lit_reopen_drop", done, 1'b0);
        repeat (TO + 1) drive(32'h0, 32'h0);
        chk("lit_reopen_rise", done, 1'b1);

        // Reset mid-load.
        do_reset();
        for (int i = 0; i < 3; i++) drive(wa(i), 32'(i + 1));
        do_reset();
        chk("lit_mid_count", count, 16'd0);
        chk("lit_mid_bank", config_out, 256'b0);
        chk("lit_mid_done", done, 1'b0);
        for (int i = 3; i < NR; i++) drive(wa(i), 32'(i + 1));
        drive(32'h0, 32'h0);
        chk("lit_mid_count5", count, 16'd5);

`ifdef CONFIG_READBACK_EN
        do_reset();
        drive(wa(1), 32'h1111_1111);
        drive(wa(1), 32'h2222_2222);
        chk("lit_rd_first", rd, 32'h0);
        drive(32'h0, 32'h0);
        chk("lit_rd_second", rd, 32'h1111_1111);
`endif

        // Randomized traffic.
        repeat (3000) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                do_reset();
            end else if (r < 4) begin
                repeat ($urandom_range(3, 9)) drive(32'h0, $urandom);
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 35)
                    a = 32'h0;
                else if (r < 80)
                    a = wa(int'($urandom_range(0, NR - 1)));
                else if (r < 88)
                    a = {8'($urandom_range(0, 7)), 8'h00, 16'(TID + 16'($urandom_range(1, 200)))};
                else if (r < 96)
                    a = {8'($urandom_range(0, 7)), 8'($urandom_range(1, 255)), TID};
                else
                    a = wa(int'($urandom_range(NR, 255)));
                drive(a, $urandom);
            end
        end
        repeat (8) drive(32'h0, 32'h0);

        checking = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
